// File: rtl/fpadder_driver.sv
// Initiator for the serial fpadder operand protocol: buffers one {A,B} pair, drives A then B
// onto the adder bus in its ready window, captures the sum and hands it downstream.
module fpadder_driver #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned CNT_W       = 10
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        fp_ready,
  output logic [31:0] fp_a,
  input  logic [31:0] fp_sum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StSendA, StSendB, StWaitRes, StResult} state_e;

  state_e             r_state;
  logic               r_rdy;
  logic               r_buf_valid;
  logic [31:0]        r_buf_a;
  logic [31:0]        r_buf_b;
  logic [31:0]        r_fp_a;
  logic               r_res_valid;
  logic [31:0]        r_res_sum;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_cnt;

  state_e             w_state_nxt;
  logic [31:0]        w_fp_a_nxt;
  logic               w_res_valid_nxt;
  logic [31:0]        w_res_sum_nxt;
  logic               w_timeout_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_buf_clr;
  logic               w_buf_load;
  logic               w_rise;

  // A window opens on the first cycle fp_ready is seen high.
  assign w_rise     = fp_ready && !r_rdy;
  assign w_buf_load = in_valid && !r_buf_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_fp_a_nxt      = '0;
    w_res_valid_nxt = r_res_valid;
    w_res_sum_nxt   = r_res_sum;
    w_timeout_nxt   = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_buf_clr       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_rise && r_buf_valid) begin
          w_fp_a_nxt  = r_buf_a;
          w_state_nxt = StSendA;
        end
      end
      StSendA: begin
        w_fp_a_nxt  = r_buf_b;
        w_state_nxt = StSendB;
      end
      StSendB: begin
        w_buf_clr   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = StWaitRes;
      end
      StWaitRes: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (w_rise) begin
          w_res_sum_nxt   = fp_sum;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = StResult;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end
      end
      StResult: begin
        if (res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state     <= StIdle;
      r_rdy       <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_a     <= '0;
      r_buf_b     <= '0;
      r_fp_a      <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rdy       <= fp_ready;
      r_fp_a      <= w_fp_a_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_sum   <= w_res_sum_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_buf_load) begin
        r_buf_valid <= 1'b1;
        r_buf_a     <= in_a;
        r_buf_b     <= in_b;
      end else if (w_buf_clr) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = !r_buf_valid;
  assign fp_a        = r_fp_a;
  assign res_valid   = r_res_valid;
  assign res_sum     = r_res_sum;
  assign timeout_err = r_timeout;
  assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_fpadder_driver.sv
// Bench for fpadder_driver: a free-running adder model plus a queue of expected results.
module tb_fpadder_driver;

  logic        clock  = 1'b0;
  logic        nreset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        fp_ready;
  logic [31:0] fp_a;
  logic [31:0] fp_sum;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_sum;
  logic        timeout_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int to_pulses = 0;
  int unsigned compute_len = 0;
  logic acc_busy;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  fpadder_driver #(.TIMEOUT_CYC(1023), .CNT_W(10)) dut (
    .clock       (clock),
    .nreset      (nreset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .fp_ready    (fp_ready),
    .fp_a        (fp_a),
    .fp_sum      (fp_sum),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // Stand-in for the IEEE add: exact for the directed pairs, a bit-mixing hash otherwise so
  // swapped or dropped operands change the result.
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'hC0000000 && b == 32'h3F800000) return 32'hBF800000;
    if (a == 32'h40A00000 && b == 32'h40A00000) return 32'h41200000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
  endfunction

  // Adder model: ready high two cycles, A sampled end of 2nd high, B end of 1st low, then compute.
  logic [1:0]  ad_phase;
  int unsigned ad_wait;
  logic [31:0] ad_a, ad_b;
  assign fp_ready = (ad_phase == 2'd0) || (ad_phase == 2'd1);

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ad_phase <= 2'd3;
      ad_wait  <= 3;
      ad_a     <= '0;
      ad_b     <= '0;
      fp_sum   <= '0;
    end else begin
      case (ad_phase)
        2'd0: ad_phase <= 2'd1;
        2'd1: begin ad_a <= fp_a; ad_phase <= 2'd2; end
        2'd2: begin
          ad_b     <= fp_a;
          ad_wait  <= (compute_len != 0) ? compute_len - 1 : $urandom_range(11, 0);
          ad_phase <= 2'd3;
        end
        default: begin
          if (ad_wait == 0) begin
            fp_sum   <= ref_sum(ad_a, ad_b);
            ad_phase <= 2'd0;
          end else begin
            ad_wait <= ad_wait - 1;
          end
        end
      endcase
    end
  end

  always @(negedge clock) if (timeout_err) to_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic submit(input logic [31:0] a, input logic [31:0] b, input bit keep);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 5000) begin tick(); n++; end
    chk("submit_ready", 32'(in_ready), 32'd1);
    acc_busy = busy;
    tick();
    in_valid = 1'b0;
    if (keep) exp_q.push_back(ref_sum(a, b));
  endtask

  task automatic wait_launch(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!busy && n < 5000) begin tick(); n++; end
    chk("launch_busy", 32'(busy), 32'd1);
    chk("launch_a", fp_a, a);
    tick();
    chk("launch_b", fp_a, b);
    tick();
    chk("launch_bus_idle", fp_a, 32'h0);
  endtask

  task automatic get_result(input string tag, input int hold);
    int n = 0;
    logic [31:0] e, s0;
    bit stable = 1'b1;
    e = 32'hDEADBEEF;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    while (!res_valid && n < 5000) begin tick(); n++; end
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_sum"}, res_sum, e);
    s0 = res_sum;
    repeat (hold) begin
      tick();
      if (!res_valid || res_sum !== s0 || fp_a !== 32'h0) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, 32'(stable), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_drop"}, 32'(res_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, win, p0;
    bit ok, prev, saw;
    logic [31:0] ra, rb;

    #2 nreset = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fp_a", fp_a, 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_sum", res_sum, 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nreset = 1'b1;
    tick();

    // Single op
    submit(32'h3F800000, 32'h40000000, 1);
    wait_launch(32'h3F800000, 32'h40000000);
    get_result("single", 0);

    // Back-pressure with an extra pair parked in the buffer
    submit(32'h40400000, 32'h3F800000, 1);
    wait_launch(32'h40400000, 32'h3F800000);
    n = 0;
    while (!res_valid && n < 5000) begin tick(); n++; end
    submit(32'hC0000000, 32'h3F800000, 1);
    chk("bp_buf_full", 32'(in_ready), 32'd0);
    get_result("bp_first", 40);
    wait_launch(32'hC0000000, 32'h3F800000);
    get_result("bp_second", 0);

    // Back-to-back: second pair accepted while the first is computing
    submit(32'h12345678, 32'h9ABCDEF0, 1);
    submit(32'h0BADF00D, 32'hFEEDFACE, 1);
    chk("b2b_acc_busy", 32'(acc_busy), 32'd1);
    get_result("b2b_first", 2);
    get_result("b2b_second", 0);

    // Idle adder windows
    prev = fp_ready; win = 0; ok = 1'b1; n = 0;
    while (win < 3 && n < 500) begin
      tick(); n++;
      if (fp_ready && !prev) win++;
      prev = fp_ready;
      if (res_valid || fp_a !== 32'h0 || busy) ok = 1'b0;
    end
    chk("idle_windows", 32'(win), 32'd3);
    chk("idle_quiet", 32'(ok), 32'd1);
    submit(32'h40A00000, 32'h40A00000, 1);
    wait_launch(32'h40A00000, 32'h40A00000);
    get_result("idle_then_op", 0);

    // Random pairs, including raw NaN/Inf patterns
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      if (i == 0) begin ra = 32'h7FC00001; rb = 32'hFF800000; end
      submit(ra, rb, 1);
      wait_launch(ra, rb);
      get_result("rand", int'($urandom_range(5, 0)));
    end

    // Result on the final allowed WAIT_RES cycle beats the timeout
    compute_len = 1023;
    submit(32'h55AA33CC, 32'h0F0F1234, 1);
    wait_launch(32'h55AA33CC, 32'h0F0F1234);
    compute_len = 0;
    p0 = to_pulses;
    get_result("prio_edge", 0);
    chk("prio_no_timeout", 32'(to_pulses - p0), 32'd0);

    // Timeout: adder stalls one cycle too long
    compute_len = 1024;
    submit(32'h11111111, 32'h22222222, 0);
    wait_launch(32'h11111111, 32'h22222222);
    compute_len = 0;
    p0 = to_pulses; n = 2; saw = 1'b0;
    while (!timeout_err && n < 3000) begin
      tick(); n++;
      if (res_valid) saw = 1'b1;
    end
    chk("to_cycles", 32'(n), 32'd1026);
    chk("to_busy", 32'(busy), 32'd0);
    repeat (30) begin tick(); if (res_valid) saw = 1'b1; end
    chk("to_no_result", 32'(saw), 32'd0);
    chk("to_pulses", 32'(to_pulses - p0), 32'd1);

    // Reset during WAIT_RES
    compute_len = 300;
    submit(32'h33333333, 32'h44444444, 0);
    wait_launch(32'h33333333, 32'h44444444);
    compute_len = 0;
    repeat (10) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_fp_a", fp_a, 32'h0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_res_sum", res_sum, 32'h0);
    chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    nreset = 1'b1;
    tick();
    submit(32'h3F800000, 32'h3F800000, 1);
    wait_launch(32'h3F800000, 32'h3F800000);
    get_result("post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
